// File: rtl/vp_pkg.sv
// rtl/vp_pkg.sv - shared types and defaults for the load-value speculation controller
package vp_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SNAP     = 3'd1,
      SPEC     = 3'd2,
      RECOVER  = 3'd3,
      REDIRECT = 3'd4
   } vp_state_t;

   localparam int VP_SPEC_TIMEOUT = 64;

endpackage

// File: rtl/vp_speculation_ctrl_spec_timer.sv
// rtl/vp_speculation_ctrl_spec_timer.sv - saturating SPEC-phase cycle counter with expire flag
module spec_timer #(
   parameter int SPEC_TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int TW = $clog2(SPEC_TIMEOUT);

   logic [TW-1:0] count_q;

   assign expire = (count_q == TW'(SPEC_TIMEOUT - 1));

   // Holds at SPEC_TIMEOUT-1 so it can never wrap back into a live window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en && !expire) begin
         count_q <= count_q + TW'(1);
      end
   end

endmodule

// File: rtl/vp_speculation_ctrl.sv
// rtl/vp_speculation_ctrl.sv - load-value speculation sequencer: snapshot, speculate, verify, recover
module vp_speculation_ctrl
   import vp_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int SPEC_TIMEOUT = VP_SPEC_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ld_req_valid,
   input  logic                  ld_req_write,
   input  logic [ADDR_WIDTH-1:0] ld_pc,
   input  logic                  pred_valid,
   input  logic [DATA_WIDTH-1:0] pred_data,
   input  logic                  dc_valid,
   input  logic [DATA_WIDTH-1:0] dc_data,
   output logic                  snap_take,
   input  logic                  snap_done,
   output logic                  restore_req,
   input  logic                  restore_done,
   output logic                  use_pred,
   output logic [DATA_WIDTH-1:0] vp_data,
   output logic                  hold_ov,
   output logic                  flush_ov,
   output logic                  load_pc_we,
   output logic [ADDR_WIDTH-1:0] load_pc_new,
   output logic                  train_valid,
   output logic [DATA_WIDTH-1:0] train_data,
   output logic                  stat_hit,
   output logic                  stat_miss
);

   vp_state_t             state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] pred_q, resp_data_q, train_data_q;
   logic                  resp_seen_q, hold_q, use_pred_q;
   logic                  hit_q, miss_q, train_q;
   logic                  expire;
   logic                  capture, resolve, match;
   logic [DATA_WIDTH-1:0] resolve_data;

   assign capture      = (state_q == IDLE) && ld_req_valid && !ld_req_write && !dc_valid && pred_valid;
   // A fill latched during SNAP wins over whatever dc_valid shows now.
   assign resolve      = resp_seen_q || dc_valid;
   assign resolve_data = resp_seen_q ? resp_data_q : dc_data;
   assign match        = (resolve_data == pred_q);

   spec_timer #(.SPEC_TIMEOUT(SPEC_TIMEOUT)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state_q == SNAP),
      .en     (state_q == SPEC),
      .expire (expire)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (capture) state_d = SNAP;
         SNAP:     if (snap_done) state_d = SPEC;
         SPEC: begin
            if (resolve)     state_d = match ? IDLE : RECOVER;
            else if (expire) state_d = RECOVER;
         end
         RECOVER:  if (restore_done) state_d = REDIRECT;
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= '0;
         pred_q       <= '0;
         resp_data_q  <= '0;
         resp_seen_q  <= 1'b0;
         hold_q       <= 1'b0;
         use_pred_q   <= 1'b0;
         hit_q        <= 1'b0;
         miss_q       <= 1'b0;
         train_q      <= 1'b0;
         train_data_q <= '0;
      end else begin
         state_q    <= state_d;
         use_pred_q <= (state_q == SNAP) && snap_done;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
         train_q    <= 1'b0;
         if (capture) begin
            pc_q        <= ld_pc;
            pred_q      <= pred_data;
            resp_seen_q <= 1'b0;
         end
         if ((state_q == SNAP) && dc_valid && !resp_seen_q) begin
            resp_seen_q <= 1'b1;
            resp_data_q <= dc_data;
         end
         if (state_q == SNAP) begin
            hold_q <= 1'b0;
         end else if ((state_q == SPEC) && ld_req_valid) begin
            hold_q <= 1'b1;
         end
         if (state_q == SPEC) begin
            if (resolve) begin
               train_q      <= 1'b1;
               train_data_q <= resolve_data;
               hit_q        <= match;
               miss_q       <= !match;
            end else if (expire) begin
               miss_q <= 1'b1;
            end
         end
      end
   end

   assign snap_take   = (state_q == SNAP);
   assign restore_req = (state_q == RECOVER);
   assign use_pred    = use_pred_q;
   assign vp_data     = pred_q;
   assign hold_ov     = (state_q == SNAP) || (state_q == RECOVER) || ((state_q == SPEC) && hold_q);
   assign flush_ov    = (state_q == RECOVER) || (state_q == REDIRECT);
   assign load_pc_we  = (state_q == REDIRECT);
   assign load_pc_new = (state_q == REDIRECT) ? pc_q : '0;
   assign train_valid = train_q;
   assign train_data  = train_data_q;
   assign stat_hit    = hit_q;
   assign stat_miss   = miss_q;

endmodule

// File: tb/tb_vp_speculation_ctrl.sv
// tb/tb_vp_speculation_ctrl.sv - self-checking bench for vp_speculation_ctrl
module tb_vp_speculation_ctrl;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ld_req_valid, ld_req_write, pred_valid, dc_valid, snap_done, restore_done;
   logic [AW-1:0] ld_pc;
   logic [DW-1:0] pred_data, dc_data;
   logic          snap_take, restore_req, use_pred, hold_ov, flush_ov, load_pc_we;
   logic          train_valid, stat_hit, stat_miss;
   logic [DW-1:0] vp_data, train_data;
   logic [AW-1:0] load_pc_new;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vp_speculation_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPEC_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ld_req_valid(ld_req_valid), .ld_req_write(ld_req_write),
      .ld_pc(ld_pc), .pred_valid(pred_valid), .pred_data(pred_data), .dc_valid(dc_valid),
      .dc_data(dc_data), .snap_take(snap_take), .snap_done(snap_done),
      .restore_req(restore_req), .restore_done(restore_done), .use_pred(use_pred),
      .vp_data(vp_data), .hold_ov(hold_ov), .flush_ov(flush_ov), .load_pc_we(load_pc_we),
      .load_pc_new(load_pc_new), .train_valid(train_valid), .train_data(train_data),
      .stat_hit(stat_hit), .stat_miss(stat_miss)
   );

   // Reference model: phase 0 idle, 1 snapshot, 2 speculating, 3 restoring, 4 redirecting.
   int            m_ph, m_cnt;
   logic [AW-1:0] m_pc;
   logic [DW-1:0] m_pred, m_rdata, m_tdata;
   logic          m_seen, m_hold, m_first, m_hit, m_miss, m_train;

   int n_we, n_hit, n_miss, n_train;
   logic [AW-1:0] last_we_pc;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      m_ph = 0; m_cnt = 0; m_pc = '0; m_pred = '0; m_rdata = '0; m_tdata = '0;
      m_seen = 0; m_hold = 0; m_first = 0; m_hit = 0; m_miss = 0; m_train = 0;
   endtask

   task automatic model_step();
      logic [DW-1:0] d;
      m_hit = 0; m_miss = 0; m_train = 0; m_first = 0;
      case (m_ph)
         0: if (ld_req_valid && !ld_req_write && pred_valid && !dc_valid) begin
               m_pc = ld_pc; m_pred = pred_data; m_seen = 0; m_ph = 1;
            end
         1: begin
               if (dc_valid && !m_seen) begin m_seen = 1; m_rdata = dc_data; end
               if (snap_done) begin m_ph = 2; m_cnt = 0; m_first = 1; m_hold = 0; end
            end
         2: begin
               if (m_seen || dc_valid) begin
                  d = m_seen ? m_rdata : dc_data;
                  m_train = 1; m_tdata = d;
                  if (d == m_pred) begin m_hit = 1; m_ph = 0; end
                  else begin m_miss = 1; m_ph = 3; end
               end else if (m_cnt == TO - 1) begin
                  m_miss = 1; m_ph = 3;
               end else begin
                  m_cnt++;
               end
               if (ld_req_valid) m_hold = 1;
            end
         3: if (restore_done) m_ph = 4;
         default: m_ph = 0;
      endcase
   endtask

   task automatic compare();
      chk("snap_take",   snap_take,   m_ph == 1);
      chk("restore_req", restore_req, m_ph == 3);
      chk("use_pred",    use_pred,    m_first);
      chk("vp_data",     vp_data,     m_pred);
      chk("hold_ov",     hold_ov,     (m_ph == 1) || (m_ph == 3) || (m_ph == 2 && m_hold));
      chk("flush_ov",    flush_ov,    (m_ph == 3) || (m_ph == 4));
      chk("load_pc_we",  load_pc_we,  m_ph == 4);
      chk("load_pc_new", load_pc_new, (m_ph == 4) ? m_pc : '0);
      chk("train_valid", train_valid, m_train);
      chk("train_data",  train_data,  m_tdata);
      chk("stat_hit",    stat_hit,    m_hit);
      chk("stat_miss",   stat_miss,   m_miss);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      if (load_pc_we) begin n_we++; last_we_pc = load_pc_new; end
      if (stat_hit) n_hit++;
      if (stat_miss) n_miss++;
      if (train_valid) n_train++;
   endtask

   task automatic idle_in();
      ld_req_valid = 0; ld_req_write = 0; ld_pc = '0; pred_valid = 0; pred_data = '0;
      dc_valid = 0; dc_data = '0; snap_done = 0; restore_done = 0;
   endtask

   task automatic clr_ev();
      n_we = 0; n_hit = 0; n_miss = 0; n_train = 0; last_we_pc = '0;
   endtask

   task automatic do_reset();
      idle_in();
      rst_n = 0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      clr_ev();
   endtask

   task automatic start_spec(input logic [DW-1:0] pred);
      ld_req_valid = 1; ld_pc = 32'h0040_0100; pred_valid = 1; pred_data = pred;
      cyc();
      idle_in();
      cyc();
      snap_done = 1;
      cyc();
      snap_done = 0;
   endtask

   typedef struct {
      logic req, wr, pv, dcv, exp_snap;
   } vec_t;
   vec_t tbl[6];

   initial begin
      int spec_cycles;
      tbl[0] = '{1, 0, 1, 1, 0};
      tbl[1] = '{1, 1, 1, 0, 0};
      tbl[2] = '{1, 0, 0, 0, 0};
      tbl[3] = '{0, 0, 1, 1, 0};
      tbl[4] = '{0, 0, 1, 0, 0};
      tbl[5] = '{1, 0, 1, 0, 1};

      idle_in();
      rst_n = 0;
      model_reset();
      clr_ev();
      #12;
      chk("reset_ctrl", {snap_take, restore_req, use_pred, hold_ov, flush_ov, load_pc_we,
                         train_valid, stat_hit, stat_miss}, '0);
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 6; i++) begin
         ld_req_valid = tbl[i].req; ld_req_write = tbl[i].wr; pred_valid = tbl[i].pv;
         dc_valid = tbl[i].dcv; ld_pc = 32'h1000 + i; pred_data = 32'h55; dc_data = 32'h66;
         cyc();
         chk("tbl_snap", snap_take, tbl[i].exp_snap);
         chk("tbl_hold", hold_ov, tbl[i].exp_snap);
         idle_in();
         if (tbl[i].exp_snap) do_reset();
      end

      // 1: correct prediction
      do_reset();
      ld_req_valid = 1; ld_pc = 32'h0040_0100; pred_valid = 1; pred_data = 32'hAA;
      cyc();
      chk("t1_snap_lat", snap_take, 1);
      idle_in();
      cyc();
      snap_done = 1;
      cyc();
      snap_done = 0;
      chk("t1_use_pred", use_pred, 1);
      chk("t1_vp_data", vp_data, 32'hAA);
      for (int i = 0; i < 4; i++) cyc();
      chk("t1_use_pred_once", use_pred, 0);
      dc_valid = 1; dc_data = 32'hAA;
      cyc();
      dc_valid = 0;
      chk("t1_hit", stat_hit, 1);
      chk("t1_train", train_data, 32'hAA);
      for (int i = 0; i < 3; i++) cyc();
      chk("t1_no_we", n_we, 0);

      // 2: misprediction
      do_reset();
      start_spec(32'hAA);
      for (int i = 0; i < 4; i++) cyc();
      dc_valid = 1; dc_data = 32'hBB;
      cyc();
      dc_valid = 0;
      chk("t2_miss", stat_miss, 1);
      chk("t2_train", train_data, 32'hBB);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t2_restore_held", restore_req, 1);
      end
      restore_done = 1;
      cyc();
      restore_done = 0;
      chk("t2_we", load_pc_we, 1);
      chk("t2_pc", load_pc_new, 32'h0040_0100);
      cyc();
      chk("t2_we_once", n_we, 1);

      // 3: fill during snapshot
      do_reset();
      ld_req_valid = 1; ld_pc = 32'h0040_0100; pred_valid = 1; pred_data = 32'hAA;
      cyc();
      idle_in();
      dc_valid = 1; dc_data = 32'hAA;
      cyc();
      dc_valid = 0; snap_done = 1;
      cyc();
      snap_done = 0;
      chk("t3_use_pred", use_pred, 1);
      cyc();
      chk("t3_hit", stat_hit, 1);
      chk("t3_hit_count", n_hit, 1);

      // 4: store during speculation
      do_reset();
      start_spec(32'hAA);
      ld_req_valid = 1; ld_req_write = 1;
      cyc();
      idle_in();
      chk("t4_hold_a", hold_ov, 1);
      cyc();
      chk("t4_hold_b", hold_ov, 1);
      dc_valid = 1; dc_data = 32'hAA;
      cyc();
      dc_valid = 0;
      chk("t4_hold_off", hold_ov, 0);
      chk("t4_hit", stat_hit, 1);

      // 5: timeout
      do_reset();
      start_spec(32'hAA);
      spec_cycles = 1;
      for (int i = 0; i < 20 && !stat_miss; i++) begin
         cyc();
         if (!stat_miss) spec_cycles++;
      end
      chk("t5_spec_cycles", spec_cycles, TO);
      chk("t5_miss", stat_miss, 1);
      chk("t5_restore", restore_req, 1);
      restore_done = 1;
      cyc();
      restore_done = 0;
      chk("t5_we", load_pc_we, 1);
      cyc();
      chk("t5_no_train", n_train, 0);

      // 6: asynchronous reset during recovery
      do_reset();
      start_spec(32'hAA);
      dc_valid = 1; dc_data = 32'hBB;
      cyc();
      dc_valid = 0;
      chk("t6_in_recover", restore_req, 1);
      #2 rst_n = 0;
      #1;
      chk("t6_rst_ctrl", {snap_take, restore_req, use_pred, hold_ov, flush_ov, load_pc_we,
                          train_valid, stat_hit, stat_miss}, '0);
      chk("t6_rst_vp", vp_data, '0);
      chk("t6_rst_pc", load_pc_new, '0);
      model_reset();
      clr_ev();
      @(negedge clk);
      rst_n = 1;
      ld_req_valid = 1; ld_pc = 32'h0040_0200; pred_valid = 1; pred_data = 32'h11;
      dc_valid = 1; dc_data = 32'h22;
      cyc();
      idle_in();
      for (int i = 0; i < 4; i++) cyc();
      chk("t6_no_we", n_we, 0);
      chk("t6_no_stat", n_hit + n_miss + n_train, 0);

      // randomized against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         ld_req_valid = ($urandom_range(0, 9) < 4);
         ld_req_write = ($urandom_range(0, 9) < 3);
         ld_pc        = $urandom;
         pred_valid   = ($urandom_range(0, 9) < 7);
         pred_data    = $urandom_range(0, 3);
         dc_valid     = ($urandom_range(0, 9) < 2);
         dc_data      = $urandom_range(0, 3);
         snap_done    = ($urandom_range(0, 9) < 3);
         restore_done = ($urandom_range(0, 9) < 3);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
